// File: rtl/neuron_accumulator_pkg.sv
// Shared definitions for the neuron accumulator slice.
//   ALU_Y_W : width of the upstream ALU result (Y plus its extension bit)
//   DATA_W  : width of the signed neuron output handed to the next layer
//   state_t : two-state handshake FSM encoding (ACCUM collects, HOLD presents)
package neuron_accumulator_pkg;

  localparam int ALU_Y_W = 17;
  localparam int DATA_W  = 16;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/neuron_accumulator_sat_relu.sv
// Activation and saturation of a wide accumulator sum down to OUT_W bits.
// Ports:
//   s       in   ACC_W  signed sum
//   relu_en in   1      1: negative sums become 0
//   data    out  OUT_W  activated, saturated value
//   sat     out  1      data was clamped to a rail
module sat_relu
  import neuron_accumulator_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int OUT_W = DATA_W
) (
  input  logic signed [ACC_W-1:0] s,
  input  logic                    relu_en,
  output logic signed [OUT_W-1:0] data,
  output logic                    sat
);

  // Returns {sat, data}. The value fits OUT_W exactly when every bit from
  // the output sign bit upward equals the accumulator sign bit.
  function automatic logic [OUT_W:0] relu_sat(input logic signed [ACC_W-1:0] v,
                                              input logic relu);
    logic                   neg;
    logic [ACC_W-OUT_W:0]   upper;
    neg   = v[ACC_W-1];
    upper = v[ACC_W-1:OUT_W-1];
    if (relu && neg)
      return '0;
    else if (!neg && (|upper))
      return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
    else if (neg && !(&upper))
      return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    else
      return {1'b0, v[OUT_W-1:0]};
  endfunction

  logic [OUT_W:0] res;

  assign res  = relu_sat(s, relu_en);
  assign sat  = res[OUT_W];
  assign data = res[OUT_W-1:0];

endmodule

// File: rtl/neuron_accumulator.sv
// Sums groups of N_TERMS consecutive ALU results into one neuron
// pre-activation, applies optional ReLU plus saturation, and presents the
// result on a valid/ready handshake. No overlap: while a result is held the
// input side is stalled.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clear           abort the current group (ignored while holding a result)
//   in_valid/ready  input handshake; in_y signed ALU result, in_co carry-out
//   out_valid/ready output handshake
//   out_data        activated, saturated sum
//   out_sat         out_data was clamped
//   out_co          OR of in_co over the group's accepted terms
//   term_cnt        terms accepted so far in the current group
module neuron_accumulator
  import neuron_accumulator_pkg::*;
#(
  parameter int IN_W    = ALU_Y_W,
  parameter int OUT_W   = DATA_W,
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 24,
  parameter bit RELU_EN = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [IN_W-1:0]        in_y,
  input  logic                          in_co,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [OUT_W-1:0]       out_data,
  output logic                          out_sat,
  output logic                          out_co,
  output logic [$clog2(N_TERMS)-1:0]    term_cnt
);

  localparam int CNT_W = $clog2(N_TERMS);

  generate
    if (N_TERMS < 2) begin : g_bad_terms
      $error("neuron_accumulator: N_TERMS must be >= 2");
    end
    if (ACC_W < IN_W + $clog2(N_TERMS)) begin : g_bad_acc_w
      $error("neuron_accumulator: ACC_W too narrow for N_TERMS terms of IN_W bits");
    end
  endgenerate

  state_t                  state, state_nxt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] y_ext;
  logic signed [ACC_W-1:0] sum_p0;
  logic                    co_sticky;
  logic                    accept;
  logic                    last;
  logic signed [OUT_W-1:0] sat_data;
  logic                    sat_flag;

  assign in_ready = (state == ST_ACCUM) && !rst;
  // clear wins over a concurrent term: the term is dropped, not accepted.
  assign accept   = in_valid && in_ready && !clear;
  assign last     = accept && (term_cnt == CNT_W'(N_TERMS - 1));
  assign y_ext    = {{(ACC_W-IN_W){in_y[IN_W-1]}}, in_y};

  // Stage p0: running sum including the current term, activated/saturated
  assign sum_p0 = acc + y_ext;

  sat_relu #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_sat_relu (
    .s       (sum_p0),
    .relu_en (RELU_EN),
    .data    (sat_data),
    .sat     (sat_flag)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_ACCUM;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    case (state)
      ST_ACCUM: begin
        if (last) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_ACCUM;
      end
      default: state_nxt = ST_ACCUM;
    endcase
  end

  // Stage p1: output registers, stable for the whole HOLD interval
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      term_cnt  <= '0;
      co_sticky <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_co    <= 1'b0;
    end else if (state == ST_ACCUM) begin
      if (clear) begin
        acc       <= '0;
        term_cnt  <= '0;
        co_sticky <= 1'b0;
      end else if (last) begin
        out_data  <= sat_data;
        out_sat   <= sat_flag;
        out_co    <= co_sticky | in_co;
        acc       <= '0;
        term_cnt  <= '0;
        co_sticky <= 1'b0;
      end else if (accept) begin
        acc       <= sum_p0;
        term_cnt  <= term_cnt + CNT_W'(1);
        co_sticky <= co_sticky | in_co;
      end
    end
  end

endmodule
